// File: rtl/bpc_dbx_dec.sv
// DBX plane decoder: unpacks a 64-bit-word bitstream of variable-length codewords
// into one 63-bit DBX plane per cycle, NUM_PLANES planes per block.
module bpc_dbx_dec #(
    parameter int unsigned NUM_PLANES = 33
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic [62:0] out_dbx_o,
    output logic        out_dbp_flag_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        out_last_o,
    output logic        err_o
);

    localparam int unsigned BUF_W  = 128;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned DBX_W  = 63;
    localparam int unsigned SIZE_W = 7;
    localparam int unsigned RUN_W  = 6;
    localparam int unsigned PW     = (NUM_PLANES > 1) ? $clog2(NUM_PLANES) : 1;

    typedef enum logic [1:0] {ST_DECODE, ST_RUN, ST_HOLD} state_t;

    state_t             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PW-1:0]      plane_q, plane_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [DBX_W-1:0]   dbx_q, dbx_d;
    logic               flag_q, flag_d, valid_q, valid_d, last_q, last_d, err_q, err_d;

    // Codeword at the top of the buffer
    logic [SIZE_W-1:0]  cw_size;
    logic [DBX_W-1:0]   cw_dbx;
    logic               cw_flag, cw_err, cw_run;
    logic [RUN_W-1:0]   cw_len;
    logic [5:0]         cw_pos;

    always_comb begin
        cw_size = SIZE_W'(64);
        cw_dbx  = buf_q[126:64];
        cw_flag = 1'b0;
        cw_err  = 1'b0;
        cw_run  = 1'b0;
        cw_len  = {1'b0, buf_q[125:121]};
        cw_pos  = buf_q[122:117];
        if (!buf_q[127]) begin
            cw_dbx = '0;
            if (buf_q[126]) begin
                cw_size = SIZE_W'(7);
                cw_run  = 1'b1;
            end else if (buf_q[125]) begin
                cw_size = SIZE_W'(3);
            end else begin
                case (buf_q[124:123])
                    2'b00: begin
                        cw_size = SIZE_W'(5);
                        cw_dbx  = '1;
                    end
                    2'b01: begin
                        cw_size = SIZE_W'(5);
                        cw_flag = 1'b1;
                    end
                    2'b10: begin
                        cw_size = SIZE_W'(11);
                        if (cw_pos > 6'd61) cw_err = 1'b1;
                        else                cw_dbx = DBX_W'(3) << cw_pos;
                    end
                    default: begin
                        cw_size = SIZE_W'(11);
                        if (cw_pos > 6'd62) cw_err = 1'b1;
                        else                cw_dbx = DBX_W'(1) << cw_pos;
                    end
                endcase
            end
        end
    end

    logic               load_en, eff_run, have, emit, consume, is_last, trunc, accept;
    logic [CNT_W-1:0]   count_after, new_count, shift;
    int unsigned        rem_after, run_total;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_DECODE;
        else        state_q <= state_d;
    end

    // Next state: HOLD marks a stalled output; otherwise pending run length selects RUN
    always_comb begin
        state_d = ST_DECODE;
        if (valid_q && !out_ready_i) state_d = ST_HOLD;
        else if (run_d != '0)        state_d = ST_RUN;
    end

    // Datapath and output next values
    always_comb begin
        load_en   = !valid_q || out_ready_i;
        eff_run   = (state_q == ST_RUN) || ((state_q == ST_HOLD) && (run_q != '0));
        have      = count_q >= CNT_W'(cw_size);
        emit      = load_en && (eff_run || have);
        consume   = load_en && !eff_run && have;
        is_last   = plane_q == PW'(NUM_PLANES - 1);
        accept    = in_valid_i && in_ready_o;
        rem_after = NUM_PLANES - 32'd1 - 32'(plane_q);
        run_total = 32'(cw_len) + 32'd1;
        trunc     = consume && cw_run && (run_total > rem_after);

        count_after = count_q - (consume ? CNT_W'(cw_size) : CNT_W'(0));
        // End of block drops the rest of the partially read word
        new_count   = (emit && is_last) ? {count_after[7:6], 6'd0} : count_after;
        shift       = count_q - new_count;
        buf_d       = (buf_q << shift)
                    | (accept ? ({in_data_i, 64'd0} >> new_count) : BUF_W'(0));
        count_d     = new_count + (accept ? CNT_W'(64) : CNT_W'(0));

        run_d   = run_q;
        plane_d = plane_q;
        dbx_d   = dbx_q;
        flag_d  = flag_q;
        valid_d = valid_q;
        last_d  = last_q;
        err_d   = err_q | (consume && (cw_err || trunc));

        if (emit) begin
            dbx_d   = eff_run ? DBX_W'(0) : cw_dbx;
            flag_d  = !eff_run && cw_flag;
            valid_d = 1'b1;
            last_d  = is_last;
            plane_d = is_last ? PW'(0) : plane_q + PW'(1);
            if (eff_run)     run_d = run_q - RUN_W'(1);
            else if (cw_run) run_d = trunc ? RUN_W'(rem_after) : RUN_W'(run_total);
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= '0;
            count_q <= '0;
            plane_q <= '0;
            run_q   <= '0;
            dbx_q   <= '0;
            flag_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
            plane_q <= plane_d;
            run_q   <= run_d;
            dbx_q   <= dbx_d;
            flag_q  <= flag_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign in_ready_o     = count_q <= CNT_W'(64);
    assign out_dbx_o      = dbx_q;
    assign out_dbp_flag_o = flag_q;
    assign out_valid_o    = valid_q;
    assign out_last_o     = last_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_bpc_dbx_dec.sv
// Bench for bpc_dbx_dec: encodes planes into a bitstream, streams it with random
// handshakes and compares decoded planes against the planes that were encoded.
module tb_bpc_dbx_dec;

    localparam int NP = 33;
    localparam int K_ZERO = 0, K_RUN = 1, K_ONES = 2, K_DBP = 3, K_CONS = 4, K_SINGLE = 5, K_RAW = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [63:0] in_data;
    logic        in_valid, in_ready;
    logic [62:0] out_dbx;
    logic        out_flag, out_valid, out_ready, out_last, err;

    logic [63:0] a_in_data;
    logic        a_in_valid, a_in_ready;
    logic [62:0] a_out_dbx;
    logic        a_out_flag, a_out_valid, a_out_ready, a_out_last, a_err;

    bpc_dbx_dec #(.NUM_PLANES(NP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .out_dbx_o(out_dbx), .out_dbp_flag_o(out_flag), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_last_o(out_last), .err_o(err)
    );

    bpc_dbx_dec #(.NUM_PLANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_data_i(a_in_data), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .out_dbx_o(a_out_dbx), .out_dbp_flag_o(a_out_flag), .out_valid_o(a_out_valid),
        .out_ready_i(a_out_ready), .out_last_o(a_out_last), .err_o(a_err)
    );

    typedef struct {
        logic [62:0] dbx;
        logic        flag;
        logic        last;
    } plane_t;

    typedef struct {
        int          kind;
        int          param;
        logic [62:0] raw;
        logic [62:0] exp_dbx;
        logic        exp_flag;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          blk_cnt = 0;
    bit          bq[$];
    logic [63:0] wq[$];
    plane_t      exp_q[$];
    vec_t        tbl[11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bitstream encoder model
    task automatic put(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bq.push_back(v[i]);
    endtask

    task automatic exp_plane(input logic [62:0] d, input logic f);
        plane_t p;
        p.dbx  = d;
        p.flag = f;
        p.last = (blk_cnt == NP - 1);
        exp_q.push_back(p);
        blk_cnt = (blk_cnt == NP - 1) ? 0 : blk_cnt + 1;
    endtask

    task automatic enc_kind(input int kind, input int param, input logic [62:0] raw);
        logic [62:0] d;
        d = '0;
        case (kind)
            K_ZERO: begin put(64'd1, 3); exp_plane(63'd0, 1'b0); end
            K_RUN: begin
                put(64'd1, 2); put(64'(param - 2), 5);
                for (int i = 0; i < param; i++) exp_plane(63'd0, 1'b0);
            end
            K_ONES: begin put(64'd0, 5); exp_plane({63{1'b1}}, 1'b0); end
            K_DBP:  begin put(64'd1, 5); exp_plane(63'd0, 1'b1); end
            K_CONS: begin
                put(64'd2, 5); put(64'(param), 6);
                if (param <= 61) begin d[param] = 1'b1; d[param + 1] = 1'b1; end
                exp_plane(d, 1'b0);
            end
            K_SINGLE: begin
                put(64'd3, 5); put(64'(param), 6);
                if (param <= 62) d[param] = 1'b1;
                exp_plane(d, 1'b0);
            end
            default: begin put(64'd1, 1); put(64'(raw), 63); exp_plane(raw, 1'b0); end
        endcase
    endtask

    task automatic fill_block();
        int rem;
        rem = NP - blk_cnt;
        if (blk_cnt != 0) begin
            if (rem >= 2) enc_kind(K_RUN, rem, '0);
            else          enc_kind(K_ZERO, 0, '0);
        end
    endtask

    task automatic flush();
        logic [63:0] w;
        while (bq.size() % 64 != 0) bq.push_back(1'b0);
        while (bq.size() > 0) begin
            for (int i = 63; i >= 0; i--) w[i] = bq.pop_front();
            wq.push_back(w);
        end
    endtask

    task automatic gen_block();
        int rem, k;
        do begin
            rem = NP - blk_cnt;
            k   = $urandom_range(0, 6);
            case (k)
                K_RUN:    if (rem >= 2) enc_kind(K_RUN, $urandom_range(2, rem), '0);
                          else          enc_kind(K_ZERO, 0, '0);
                K_CONS:   enc_kind(K_CONS, $urandom_range(0, 61), '0);
                K_SINGLE: enc_kind(K_SINGLE, $urandom_range(0, 62), '0);
                K_RAW:    enc_kind(K_RAW, 0, 63'({$urandom(), $urandom()}));
                default:  enc_kind(k, 0, '0);
            endcase
        end while (blk_cnt != 0);
        flush();
    endtask

    // Streams wq into the DUT and checks every transferred plane against exp_q
    task automatic run_stream(input int rdy_pct, input int vld_pct, input int max_cyc);
        int          cyc;
        logic        held;
        logic [62:0] held_dbx;
        plane_t      p;
        cyc  = 0;
        held = 1'b0;
        held_dbx = '0;
        while ((exp_q.size() > 0 || wq.size() > 0) && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (held) check("hold_stable", {out_valid, out_dbx}, {1'b1, held_dbx});
            out_ready = ($urandom_range(1, 100) <= rdy_pct);
            held      = out_valid && !out_ready;
            held_dbx  = out_dbx;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_plane", {out_dbx, out_flag, out_last}, '0);
                end else begin
                    p = exp_q.pop_front();
                    check("plane", {out_dbx, out_flag, out_last}, {p.dbx, p.flag, p.last});
                end
            end
            in_valid = (wq.size() > 0) && ($urandom_range(1, 100) <= vld_pct);
            in_data  = (wq.size() > 0) ? wq[0] : '0;
            if (in_valid && in_ready) void'(wq.pop_front());
        end
        check("stream_done", exp_q.size() + wq.size(), 0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_valid", out_valid, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        wq.delete();
        exp_q.delete();
        bq.delete();
        blk_cnt = 0;
        @(negedge clk);
        check("reset_state", {out_valid, out_dbx, out_flag, out_last, err, in_ready}, {67'd0, 1'b1});
        rst_n = 1'b1;
    endtask

    task automatic dut1_word(input logic [63:0] w);
        int got;
        got = 0;
        @(negedge clk);
        a_in_valid = 1'b1;
        a_in_data  = w;
        check("a_in_ready", a_in_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_in_valid = 1'b0;
            if (a_out_valid) begin
                got++;
                check("a_plane", {a_out_dbx, a_out_flag, a_out_last}, {63'd0, 1'b0, 1'b1});
            end
        end
        check("a_plane_count", got, 1);
        check("a_in_ready_after", a_in_ready, 1'b1);
    endtask

    initial begin
        tbl[0]  = '{K_ZERO,    0, 63'd0, 63'd0, 1'b0};
        tbl[1]  = '{K_ONES,    0, 63'd0, 63'h7FFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[2]  = '{K_DBP,     0, 63'd0, 63'd0, 1'b1};
        tbl[3]  = '{K_CONS,    5, 63'd0, 63'h60, 1'b0};
        tbl[4]  = '{K_CONS,    0, 63'd0, 63'h3, 1'b0};
        tbl[5]  = '{K_CONS,   61, 63'd0, 63'h6000_0000_0000_0000, 1'b0};
        tbl[6]  = '{K_SINGLE, 62, 63'd0, 63'h4000_0000_0000_0000, 1'b0};
        tbl[7]  = '{K_SINGLE,  0, 63'd0, 63'h1, 1'b0};
        tbl[8]  = '{K_RAW,     0, 63'h5A5A_5A5A_5A5A_5A5A, 63'h5A5A_5A5A_5A5A_5A5A, 1'b0};
        tbl[9]  = '{K_RUN,    33, 63'd0, 63'd0, 1'b0};
        tbl[10] = '{K_RUN,     2, 63'd0, 63'd0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outputs", {out_valid, out_dbx, out_flag, out_last, err}, '0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_a_outputs", {a_out_valid, a_out_last, a_err}, '0);
        rst_n = 1'b1;

        // Single-plane blocks: second word decodes cleanly only if padding was dropped
        dut1_word(64'h2000_0000_0000_0000);
        dut1_word(64'h2000_0000_0000_0000);

        // Two-cycle latency from word accept to first valid plane
        enc_kind(K_ZERO, 0, '0); fill_block(); flush();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = wq[0];
        check("lat_accept", in_ready, 1'b1);
        void'(wq.pop_front());
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_n1_not_valid", out_valid, 1'b0);
        @(negedge clk);
        check("lat_n2_plane", {out_valid, out_dbx, out_last}, {1'b1, 63'd0, 1'b0});
        void'(exp_q.pop_front());
        run_stream(100, 100, 500);

        // Single-codeword vectors, each completed with a zero run
        foreach (tbl[i]) begin
            enc_kind(tbl[i].kind, tbl[i].param, tbl[i].raw);
            exp_q[0].dbx  = tbl[i].exp_dbx;
            exp_q[0].flag = tbl[i].exp_flag;
            fill_block();
            flush();
            run_stream(100, 100, 500);
            check("tbl_no_err", err, 1'b0);
        end

        // Raw plane straddling two words while the output is stalled
        do_reset();
        enc_kind(K_ZERO, 0, '0);
        enc_kind(K_RAW, 0, 63'h5A5A_5A5A_5A5A_5A5A);
        fill_block(); flush();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = wq[0];
            check("stall_accept", in_ready, 1'b1);
            void'(wq.pop_front());
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_low", {in_ready, out_valid, out_dbx}, {1'b0, 1'b1, 63'd0});
        repeat (5) @(negedge clk);
        check("in_ready_still_low", {in_ready, out_valid, out_dbx}, {1'b0, 1'b1, 63'd0});
        run_stream(70, 100, 1000);

        // Randomized multi-block stream with back-pressure on both sides
        do_reset();
        for (int b = 0; b < 15; b++) gen_block();
        run_stream(60, 70, 20000);
        check("random_no_err", err, 1'b0);

        // Reset mid-block drops everything buffered
        do_reset();
        gen_block();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = wq[0];
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        do_reset();
        enc_kind(K_CONS, 5, '0); fill_block(); flush();
        run_stream(100, 100, 500);

        // Zero run overrunning the block end is truncated and flagged
        do_reset();
        enc_kind(K_ZERO, 0, '0);
        put(64'd1, 2); put(64'd31, 5);
        for (int i = 0; i < NP - 1; i++) exp_plane(63'd0, 1'b0);
        flush();
        run_stream(100, 100, 500);
        check("trunc_err", err, 1'b1);

        // Out-of-range consecutive position
        do_reset();
        enc_kind(K_CONS, 62, '0); fill_block(); flush();
        run_stream(100, 100, 500);
        check("cons62_err", err, 1'b1);

        // Out-of-range single position; error stays set until reset
        do_reset();
        enc_kind(K_SINGLE, 63, '0); fill_block(); flush();
        run_stream(80, 100, 500);
        check("single63_err", err, 1'b1);
        enc_kind(K_ZERO, 0, '0); fill_block(); flush();
        run_stream(100, 100, 500);
        check("err_sticky", err, 1'b1);
        do_reset();
        check("err_cleared", err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bpc_dbx_dec.md
BPC_DBX_DEC -- requirements
Module: bpc_dbx_dec

Interface
REQ-001 Parameter NUM_PLANES, default 33, is the number of DBX planes per compressed block.
REQ-002 clk  input  1  Single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  Asynchronous, active-low reset.
REQ-004 in_data_i  input  64  Compressed bitstream word; bit 63 is the first bit in stream order.
REQ-005 in_valid_i / in_ready_o  input / output  1 / 1  Word handshake; the transfer occurs when both are high.
REQ-006 out_dbx_o  output  63  Reconstructed DBX plane.
REQ-007 out_dbp_flag_o  output  1  High when the plane was coded as DBP-flag (prefix 00001).
REQ-008 out_valid_o / out_ready_i  output / input  1 / 1  Plane handshake; the transfer occurs when both are high.
REQ-009 out_last_o  output  1  High with plane NUM_PLANES-1 of the block.
REQ-010 err_o  output  1  Sticky protocol-error flag.

Function
REQ-011 The decoder SHALL hold a 128-bit MSB-aligned bit buffer with a count (0..128); bits below count are zero.
REQ-012 in_ready_o SHALL equal (count <= 64); an accepted word is appended directly below the unread bits.
REQ-013 Codeword size and value SHALL be decoded from the buffer top bits as follows:
  - 001: one zero plane, size 3.
  - 01+5b L: L+2 zero planes (2..33), size 7.
  - 00000: all-ones plane, size 5.
  - 00001: dbx = 0 with out_dbp_flag_o = 1, size 5.
  - 00010+6b p: bits p and p+1 set, size 11.
  - 00011+6b p: bit p set, size 11.
  - 1+63b: raw plane, size 64.
REQ-014 A codeword SHALL be consumed only when count >= size; decode/consume and word accept in the same cycle SHALL yield count - size + 64.
REQ-015 The FSM SHALL have states DECODE, RUN and HOLD.
  - DECODE: emits one plane per cycle.
  - A zero-run code moves to RUN, which emits the remaining L+1 zero planes, one per accepted plane, without consuming bits.
  - HOLD is entered while out_valid_o is high and out_ready_i is low; the output is held stable in HOLD.
REQ-016 The output register SHALL load a new plane whenever it is empty or being drained that cycle, giving 1 plane/cycle throughput.
REQ-017 Latency: a word accepted in cycle N SHALL give its first plane with out_valid_o high in cycle N+2.
REQ-018 A plane counter 0..NUM_PLANES-1 SHALL drive out_last_o and wrap to 0 after the last plane transfers.
REQ-019 When the last plane's codeword is consumed, unread bits of the partially read word SHALL be discarded (count := count - size rounded down to a multiple of 64); later whole words are kept.
REQ-020 The following SHALL set err_o and output a zero plane:
  - consecutive-code position p > 61;
  - single-code position p > 62.
REQ-021 A zero run that extends past plane NUM_PLANES-1 SHALL be truncated at the last plane and SHALL set err_o.

Reset
REQ-022 While rst_n is low, the decoder SHALL reset to:
  - count = 0, buffer = 0, plane counter = 0, FSM = DECODE;
  - out_valid_o = 0, out_dbx_o = 0, out_dbp_flag_o = 0, out_last_o = 0, err_o = 0.
REQ-023 Reset asserted mid-block or mid-run SHALL discard all buffered bits and pending planes; the first word after release starts a new block.

Verification
REQ-024 Input word 64'h2000_0000_0000_0000 (001, then zero pad), NUM_PLANES = 1 -> one plane, dbx = 0, out_last_o = 1, count returns to 0.
REQ-025 Input word 0x10 prefix (00010) with p = 6'd5 -> dbx = 63'h60; single-code (00011) with p = 6'd62 -> dbx = bit 62 set.
REQ-026 Input word starting 01+5'd31 (33-plane run), NUM_PLANES = 33 -> 33 zero planes on consecutive cycles with out_ready_i high; out_last_o only on the 33rd.
REQ-027 Raw codeword {1'b1, 63'h5A5A...} spanning two input words -> exact plane; in_ready_o deasserts when count exceeds 64.
REQ-028 out_ready_i held low for 5 cycles mid-block -> out_dbx_o stable, no planes lost or duplicated; 00011+6'd63 -> err_o = 1 until reset.
